// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the X-Makina register file.
// Round-robin among REQUESTERS writeback sources sharing one byte-enabled
// write port, plus a PC-update port that is normally lowest priority but is
// forced through after PC_STARVE cycles of waiting. Outputs are registered
// and feed the register file's wren/wraddr/data/pcen/pc inputs directly.
module regfile_wr_arbiter #(
  parameter int WORD       = 16,
  parameter int REGISTERS  = 8,
  parameter int REQUESTERS = 3,
  parameter int PC_STARVE  = 4
) (
  input  logic                                      clk_i,
  input  logic                                      arst_i,
  input  logic [REQUESTERS-1:0]                     req_valid_i,
  output logic [REQUESTERS-1:0]                     req_ready_o,
  input  logic [REQUESTERS-1:0][WORD/8-1:0]         req_wren_i,
  input  logic [REQUESTERS-1:0][$clog2(REGISTERS)-1:0] req_addr_i,
  input  logic [REQUESTERS-1:0][WORD-1:0]           req_data_i,
  input  logic                                      pc_valid_i,
  output logic                                      pc_ready_o,
  input  logic [WORD-1:0]                           pc_i,
  output logic [WORD/8-1:0]                         wren_o,
  output logic [$clog2(REGISTERS)-1:0]              wraddr_o,
  output logic [WORD-1:0]                           data_o,
  output logic                                      pcen_o,
  output logic [WORD-1:0]                           pc_o,
  output logic [$clog2(REQUESTERS+1)-1:0]           grant_id_o
);

  localparam int BE = WORD / 8;
  localparam int AW = $clog2(REGISTERS);
  localparam int GW = $clog2(REQUESTERS + 1);
  localparam int RW = $clog2(REQUESTERS);
  localparam int SW = $clog2(PC_STARVE + 1);

  // (a + k) mod REQUESTERS, with k never exceeding REQUESTERS
  function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= REQUESTERS) s = s - REQUESTERS;
    return RW'(s);
  endfunction

  // arbitration state
  logic [RW-1:0]   rr_q, rr_d;
  logic [SW-1:0]   starve_q, starve_d;

  // registered outputs
  logic [BE-1:0]   wren_q, wren_d;
  logic [AW-1:0]   wraddr_q, wraddr_d;
  logic [WORD-1:0] data_q, data_d;
  logic            pcen_q, pcen_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [GW-1:0]   gid_q, gid_d;

  // arbitration results
  logic            forced;
  logic            found;
  logic [RW-1:0]   gnt_idx;
  logic            req_hs;
  logic            pc_hs;

  assign forced = (starve_q == SW'(PC_STARVE));

  // Round-robin search starting at rr: first valid requester wins
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (!found && req_valid_i[wrap_add(rr_q, k)]) begin
        found   = 1'b1;
        gnt_idx = wrap_add(rr_q, k);
      end
    end
  end

  // Grants: a forced PC slot blocks all requesters; otherwise PC only
  // wins when no requester is asking. Nothing is granted while in reset so
  // no handshake can be lost to the output clear.
  always_comb begin
    req_ready_o = '0;
    if (!arst_i && !forced && found) req_ready_o[gnt_idx] = 1'b1;
    pc_ready_o = !arst_i && pc_valid_i && (forced || (req_valid_i == '0));
  end

  assign req_hs = |(req_valid_i & req_ready_o);
  assign pc_hs  = pc_valid_i && pc_ready_o;

  // Next-state: pointer, starvation counter and output register contents
  always_comb begin
    rr_d     = rr_q;
    starve_d = starve_q;
    wren_d   = '0;
    wraddr_d = wraddr_q;
    data_d   = data_q;
    pcen_d   = 1'b0;
    pc_d     = pc_q;
    gid_d    = GW'(REQUESTERS);

    if (req_hs) rr_d = wrap_add(gnt_idx, 1);

    if (!pc_valid_i || pc_hs)
      starve_d = '0;
    else if (!forced)
      starve_d = starve_q + SW'(1);

    if (req_hs) begin
      wren_d   = req_wren_i[gnt_idx];
      wraddr_d = req_addr_i[gnt_idx];
      data_d   = req_data_i[gnt_idx];
      gid_d    = GW'(gnt_idx);
    end else if (pc_hs) begin
      pcen_d   = 1'b1;
      pc_d     = pc_i;
    end
  end

  // State and output registers; reset discards any pending output
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rr_q     <= '0;
      starve_q <= '0;
      wren_q   <= '0;
      wraddr_q <= '0;
      data_q   <= '0;
      pcen_q   <= 1'b0;
      pc_q     <= '0;
      gid_q    <= GW'(REQUESTERS);
    end else begin
      rr_q     <= rr_d;
      starve_q <= starve_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      data_q   <= data_d;
      pcen_q   <= pcen_d;
      pc_q     <= pc_d;
      gid_q    <= gid_d;
    end
  end

  assign wren_o     = wren_q;
  assign wraddr_o   = wraddr_q;
  assign data_o     = data_q;
  assign pcen_o     = pcen_q;
  assign pc_o       = pc_q;
  assign grant_id_o = gid_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: stimulus pushes expected output
// beats, a negedge monitor pops and compares whenever an output is presented.
module tb_regfile_wr_arbiter;

  localparam int W  = 16;
  localparam int R  = 8;
  localparam int N  = 3;
  localparam int PS = 4;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]        rv;
  logic [N-1:0]        rrdy;
  logic [N-1:0][1:0]   rwren;
  logic [N-1:0][2:0]   raddr;
  logic [N-1:0][15:0]  rdata;
  logic                pcv;
  logic                pcr;
  logic [15:0]         pci;
  logic [1:0]          wren_o;
  logic [2:0]          wraddr_o;
  logic [15:0]         data_o;
  logic                pcen_o;
  logic [15:0]         pc_o;
  logic [1:0]          gid_o;

  regfile_wr_arbiter #(.WORD(W), .REGISTERS(R), .REQUESTERS(N), .PC_STARVE(PS)) dut (
    .clk_i(clk), .arst_i(arst),
    .req_valid_i(rv), .req_ready_o(rrdy),
    .req_wren_i(rwren), .req_addr_i(raddr), .req_data_i(rdata),
    .pc_valid_i(pcv), .pc_ready_o(pcr), .pc_i(pci),
    .wren_o(wren_o), .wraddr_o(wraddr_o), .data_o(data_o),
    .pcen_o(pcen_o), .pc_o(pc_o), .grant_id_o(gid_o)
  );

  typedef struct {
    logic [1:0]  gid;
    logic [1:0]  wren;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        pcen;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_req(input int i);
    exp_t e;
    e.gid = 2'(i); e.wren = rwren[i]; e.addr = raddr[i]; e.data = rdata[i];
    e.pcen = 1'b0; e.pc = 16'h0;
    exp_q.push_back(e);
  endtask

  task automatic push_pc();
    exp_t e;
    e.gid = 2'd3; e.wren = 2'b00; e.addr = 3'd0; e.data = 16'h0;
    e.pcen = 1'b1; e.pc = pci;
    exp_q.push_back(e);
  endtask

  // one directed cycle: inputs already driven; check hand-computed grants
  task automatic cyc(input logic [N-1:0] er, input logic ep, input string nm);
    @(negedge clk);
    chk({nm, " req_ready"}, 32'(rrdy), 32'(er));
    chk({nm, " pc_ready"}, 32'(pcr), 32'(ep));
    for (int i = 0; i < N; i++) if (er[i]) push_req(i);
    if (ep) push_pc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] we, input logic [2:0] a, input logic [15:0] d);
    rwren[i] = we; raddr[i] = a; rdata[i] = d;
  endtask

  // monitor: invariants every cycle, scoreboard pop on every presented output
  always @(negedge clk) begin
    if (!arst) begin
      chk("one_ready", 32'($countones({rrdy, pcr}) <= 1), 32'd1);
      chk("wren_pcen_excl", 32'((wren_o != 2'b00) && pcen_o), 32'd0);
      if (gid_o != 2'd3 || pcen_o) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output gid=%0d pcen=%0d required=no output", gid_o, pcen_o);
        end else begin
          me = exp_q.pop_front();
          chk("out_gid", 32'(gid_o), 32'(me.gid));
          chk("out_wren", 32'(wren_o), 32'(me.wren));
          chk("out_pcen", 32'(pcen_o), 32'(me.pcen));
          if (me.pcen) chk("out_pc", 32'(pc_o), 32'(me.pc));
          else begin
            chk("out_addr", 32'(wraddr_o), 32'(me.addr));
            chk("out_data", 32'(data_o), 32'(me.data));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // reference arbitration model for the random phase
  int          m_rr, m_starve, m_g;
  logic        m_pcr, m_forced;
  logic [N-1:0] m_rdy;

  initial begin
    rv = '0; pcv = 1'b0; pci = 16'h0;
    rwren = '0; raddr = '0; rdata = '0;

    // reset state with requester 1 pending
    set_req(1, 2'b11, 3'd5, 16'h1234); rv = 3'b010;
    @(negedge clk);
    chk("rst wren", 32'(wren_o), 0);
    chk("rst wraddr", 32'(wraddr_o), 0);
    chk("rst data", 32'(data_o), 0);
    chk("rst pcen", 32'(pcen_o), 0);
    chk("rst pc", 32'(pc_o), 0);
    chk("rst gid", 32'(gid_o), 3);
    chk("rst ready", 32'({rrdy, pcr}), 0);
    @(posedge clk); #1 arst = 1'b0;
    cyc(3'b010, 1'b0, "rst_release");
    rv = '0;

    // reset mid-cycle while an output is presented: it is dropped
    rv = 3'b010;
    cyc(3'b010, 1'b0, "pre_reset");   // rr was 2, search 2,0,1 -> 1
    rv = '0;
    #3 arst = 1'b1; exp_q.delete();
    #1;
    chk("midrst wren", 32'(wren_o), 0);
    chk("midrst gid", 32'(gid_o), 3);
    chk("midrst data", 32'(data_o), 0);
    chk("midrst wraddr", 32'(wraddr_o), 0);
    @(posedge clk); #1 arst = 1'b0;

    // round-robin with all three continuously valid
    set_req(0, 2'b11, 3'd1, 16'h1111);
    set_req(1, 2'b11, 3'd2, 16'h2222);
    set_req(2, 2'b11, 3'd3, 16'h3333);
    rv = 3'b111;
    cyc(3'b001, 1'b0, "rr0"); cyc(3'b010, 1'b0, "rr1"); cyc(3'b100, 1'b0, "rr2");
    cyc(3'b001, 1'b0, "rr3"); cyc(3'b010, 1'b0, "rr4"); cyc(3'b100, 1'b0, "rr5");
    rv = '0;
    cyc(3'b000, 1'b0, "idle");

    // byte enable, then zero byte-enable still advances rr
    set_req(2, 2'b10, 3'd4, 16'hAB00); rv = 3'b100;
    cyc(3'b100, 1'b0, "be_hi");       // rr 0 -> 0
    set_req(0, 2'b00, 3'd7, 16'h5555); rv = 3'b001;
    cyc(3'b001, 1'b0, "be_zero");     // rr -> 1
    set_req(0, 2'b11, 3'd1, 16'h1111); rv = 3'b011;
    cyc(3'b010, 1'b0, "rr_adv");      // rr 1 picks 1 before 0
    rv = 3'b001;
    cyc(3'b001, 1'b0, "rr_adv2");     // rr -> 1
    rv = '0;

    // starvation: requesters saturate, PC forced in the 5th cycle
    rv = 3'b111; pcv = 1'b1; pci = 16'h0200;
    cyc(3'b010, 1'b0, "stv1"); cyc(3'b100, 1'b0, "stv2");
    cyc(3'b001, 1'b0, "stv3"); cyc(3'b010, 1'b0, "stv4");
    cyc(3'b000, 1'b1, "stv5");
    pcv = 1'b0;
    cyc(3'b100, 1'b0, "stv_after");   // rr was 2
    rv = '0;

    // PC alone is accepted in the same cycle and pulses once
    pcv = 1'b1; pci = 16'h0300;
    cyc(3'b000, 1'b1, "pc_idle");
    pcv = 1'b0;
    cyc(3'b000, 1'b0, "pc_idle_after1");
    cyc(3'b000, 1'b0, "pc_idle_after2");

    // random traffic against the reference model
    arst = 1'b1; exp_q.delete();
    @(posedge clk); #1 arst = 1'b0;
    m_rr = 0; m_starve = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) if (!rv[i]) begin
        rv[i] = 1'($urandom_range(0, 1));
        set_req(i, 2'($urandom), 3'($urandom), 16'($urandom));
      end
      if (!pcv) begin
        pcv = ($urandom_range(0, 3) == 0);
        pci = 16'($urandom);
      end
      @(negedge clk);
      m_forced = (m_starve == PS);
      m_g = -1;
      if (!m_forced)
        for (int k = 0; k < N; k++)
          if (m_g < 0 && rv[(m_rr + k) % N]) m_g = (m_rr + k) % N;
      m_rdy = '0;
      if (m_g >= 0) m_rdy[m_g] = 1'b1;
      m_pcr = pcv && (m_forced || rv == '0);
      chk("rnd req_ready", 32'(rrdy), 32'(m_rdy));
      chk("rnd pc_ready", 32'(pcr), 32'(m_pcr));
      if (m_g >= 0) push_req(m_g);
      if (m_pcr) push_pc();
      if (m_g >= 0) m_rr = (m_g + 1) % N;
      if (!pcv || m_pcr) m_starve = 0;
      else if (m_starve < PS) m_starve++;
      @(posedge clk); #1;
      if (m_g >= 0) rv[m_g] = 1'b0;
      if (m_pcr) pcv = 1'b0;
    end

    rv = '0; pcv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter for the X-Makina register file. It shares the file's single byte-enabled write port and its PC-update port among several writeback requesters (ALU, memory load, exception/link unit) with a valid/ready handshake. Arbitration is round-robin, and a PC-starvation counter bounds how long the PC update can be deferred. Outputs are registered and connect directly to the register file's `wren_i`/`wraddr_i`/`data_i`/`pcen_i`/`pc_i`.

## Interface
- `WORD`, 16: register width in bits; a multiple of 8.
- `REGISTERS`, 8: register count; sets the address width to `$clog2(REGISTERS)`.
- `REQUESTERS`, 3: number of writeback requesters; at least 2.
- `PC_STARVE`, 4: consecutive cycles a pending PC update may wait before it is forced through; at least 1.

- `clk_i` in 1: clock; all state updates on posedge.
- `arst_i` in 1: asynchronous active-high reset.
- `req_valid_i[REQUESTERS]` in 1: requester write pending.
- `req_ready_o[REQUESTERS]` out 1: grant; handshake = valid & ready.
- `req_wren_i[REQUESTERS]` in WORD/8: byte enables.
- `req_addr_i[REQUESTERS]` in $clog2(REGISTERS): destination register.
- `req_data_i[REQUESTERS]` in WORD: write data.
- `pc_valid_i` in 1: PC update pending.
- `pc_ready_o` out 1: PC grant.
- `pc_i` in WORD: new PC value.
- `wren_o` out WORD/8: to the register file `wren_i`.
- `wraddr_o` out $clog2(REGISTERS): to `wraddr_i`.
- `data_o` out WORD: to `data_i`.
- `pcen_o` out 1: to `pcen_i`.
- `pc_o` out WORD: to `pc_i`.
- `grant_id_o` out $clog2(REQUESTERS+1): source of the current output. Values 0..REQUESTERS-1 identify a requester; REQUESTERS means PC or idle.

## Operation
- **Grant limit.** At most one grant per cycle. Ready signals are combinational from valids and state; at most one of `req_ready_o`/`pc_ready_o` is high.
- **Round-robin order.** Pointer `rr` is in 0..REQUESTERS-1. Search order is `rr`, `rr+1`, … with wrap mod REQUESTERS. The first valid requester is granted.
- **Pointer update.** After a requester grant i, `rr` ← (i+1) mod REQUESTERS. `rr` is unchanged on a PC grant or an idle cycle.
- **Normal PC grant.** `pc_ready_o` = `pc_valid_i` & no `req_valid_i` high.
- **Forced PC grant.** When `starve` == PC_STARVE, `pc_ready_o` = `pc_valid_i` and all `req_ready_o` = 0.
- **Starvation counter `starve`.**
  - Increments (saturating at PC_STARVE) each cycle `pc_valid_i` & !`pc_ready_o`.
  - Clears on PC handshake or when `pc_valid_i` = 0.
- **Zero byte-enable request.** A request with `req_wren_i` = 0 still handshakes and advances `rr`, but produces `wren_o` = 0.
- **Output register, on handshake.**
  - Requester handshake: `wren_o`/`wraddr_o`/`data_o` ← granted requester fields; `pcen_o` ← 0; `grant_id_o` ← i.
  - PC handshake: `pcen_o` ← 1; `pc_o` ← `pc_i`; `wren_o` ← 0; `grant_id_o` ← REQUESTERS.
- **Output register, no handshake.** `wren_o` ← 0, `pcen_o` ← 0, `grant_id_o` ← REQUESTERS. Address and data hold their previous values.
- **Write/PC exclusivity.** `wren_o` ≠ 0 and `pcen_o` = 1 never occur together. The register file's wren-over-pcen priority is therefore never exercised.

## Timing
- **Reset.** All outputs are 0 except `grant_id_o` = REQUESTERS. `rr` = 0 and `starve` = 0.
- **Reset mid-handshake.** Any pending output is discarded. The next write occurs only after reset deasserts and a new handshake completes.
- **Latency.** A handshake in cycle N drives the outputs in cycle N+1. The register file captures the value at the end of N+1, and it is readable asynchronously from cycle N+2.
- **Throughput.** One write per cycle sustained, with no bubbles between back-to-back grants.
- **Requester obligations.** Hold `req_*` stable while valid & !ready. Valid must not drop before the handshake.
- **Starvation bound.** A PC request waits at most PC_STARVE cycles before it is accepted, under any requester load.
- **Fairness bound.** With all requesters continuously valid and no PC request, each requester is granted exactly once every REQUESTERS cycles.

## Test plan
- **Reset.** Assert `arst_i` mid-cycle with requester 1 valid → outputs zero immediately, `grant_id_o` = 3. After release, requester 1 is granted on the first edge and `wren_o` = 2'b11 appears on the next cycle.
- **Round-robin.** All 3 requesters valid continuously (addresses 1, 2, 3; data 0x1111, 0x2222, 0x3333) → `grant_id_o` sequence 0, 1, 2, 0, 1, 2. Each requester's data appears on `data_o` in the cycle after its grant.
- **Byte enable.** Requester 2 writes `wren` = 2'b10, data 0xAB00 to R4 → `wren_o` = 2'b10, `wraddr_o` = 4 one cycle later. A request with `wren` = 0 handshakes with `wren_o` = 0 and `rr` advances.
- **Starvation.** `pc_valid_i` held with `pc_i` = 0x0200 and requesters saturating → `pc_ready_o` rises exactly in the 5th cycle (`starve` = 4). `pcen_o` = 1 and `pc_o` = 0x0200 the next cycle. No `req_ready_o` is high that cycle.
- **Idle PC.** PC only, no requesters → `pc_ready_o` in the same cycle, `pcen_o` pulses for 1 cycle, `starve` stays 0.
- **Exclusivity assertion.** Random valids over 10k cycles → `wren_o` ≠ 0 and `pcen_o` are never high together. At most one ready is high each cycle. Every accepted request appears exactly once at the outputs, in grant order.
